// File: rtl/crc32_pkg.sv
// IEEE 802.3 CRC-32 constants and the byte-wide next-state function.
// The register is held MSB-first (non-reflected); wire bit d[0] is folded in first.
package crc32_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704_DD7B;

  // Loop is fully unrolled by synthesis into a single XOR network per byte.
  function automatic logic [31:0] crc32_d8_next(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = {c[30:0], 1'b0} ^ ((c[31] ^ d[i]) ? CRC32_POLY : 32'h0);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_d8_xor.sv
// Combinational one-byte CRC-32 advance; shared with the switch RX FCS checker.
module crc32_d8_xor
  import crc32_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_d,
  output logic [31:0] o_crc_next
);

  assign o_crc_next = crc32_d8_next(i_crc, i_d);

endmodule

// File: rtl/crc32_ieee8023.sv
// Byte-wide Ethernet FCS generator/checker: accumulates over data bytes with calc=1,
// then serialises the FCS one byte per calc=0 strobe in wire order.
module crc32_ieee8023
  import crc32_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  d,
  input  logic        load_init,
  input  logic        calc,
  input  logic        d_valid,
  output logic [31:0] crc_reg,
  output logic [7:0]  crc
);

  logic [31:0] r_crc;
  logic [31:0] w_crc_next;

  crc32_d8_xor u_xor (
    .i_crc      (r_crc),
    .i_d        (d),
    .o_crc_next (w_crc_next)
  );

  // Shifting in 0xFF leaves the register at CRC32_INIT after the fourth FCS byte.
  always_ff @(posedge clk) begin
    if (reset)                  r_crc <= CRC32_INIT;
    else if (load_init)         r_crc <= CRC32_INIT;
    else if (d_valid && calc)   r_crc <= w_crc_next;
    else if (d_valid)           r_crc <= {r_crc[23:0], 8'hFF};
  end

  assign crc_reg = r_crc;

  // Next FCS byte: complemented top byte, bit-reversed so crc[0] goes on the wire first.
  always_comb begin
    crc = 8'h00;
    for (int i = 0; i < 8; i++) crc[i] = ~r_crc[31-i];
  end

endmodule

// File: tb/tb_crc32_ieee8023.sv
// Directed bench for crc32_ieee8023: known vector, residue, alternating strobes, priority.
module tb_crc32_ieee8023;
  import crc32_pkg::*;

  logic        clk = 1'b0;
  logic        reset, load_init, calc, d_valid;
  logic [7:0]  d;
  logic [31:0] crc_reg;
  logic [7:0]  crc;

  int n_chk = 0;
  int n_err = 0;

  crc32_ieee8023 dut (
    .clk(clk), .reset(reset), .d(d), .load_init(load_init),
    .calc(calc), .d_valid(d_valid), .crc_reg(crc_reg), .crc(crc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // One clock with the given strobes; outputs are sampled 1ns after the edge.
  task automatic drive(input logic li, input logic c, input logic v, input logic [7:0] dd);
    load_init = li; calc = c; d_valid = v; d = dd;
    @(posedge clk); #1;
    load_init = 1'b0; calc = 1'b0; d_valid = 1'b0; d = 8'h00;
  endtask

  // Reflected (LSB-first) software CRC; its state is the bit-reverse of crc_reg.
  function automatic logic [31:0] sw_crc(input logic [31:0] r, input logic [7:0] b);
    logic [31:0] x;
    x = r ^ {24'h0, b};
    for (int i = 0; i < 8; i++) x = x[0] ? ((x >> 1) ^ 32'hEDB8_8320) : (x >> 1);
    return x;
  endfunction

  function automatic logic [31:0] rev32(input logic [31:0] x);
    logic [31:0] y;
    for (int i = 0; i < 32; i++) y[i] = x[31-i];
    return y;
  endfunction

  logic [7:0]  s123 [9];
  logic [7:0]  fcs_k [4];
  logic [7:0]  frame [100];
  logic [31:0] m, fcs;

  initial begin
    s123  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    fcs_k = '{8'h26, 8'h39, 8'hF4, 8'hCB};
    reset = 1'b1; load_init = 1'b0; calc = 1'b0; d_valid = 1'b0; d = 8'h00;

    // Reset
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    chk("reset_crc_reg", crc_reg, 32'hFFFF_FFFF);
    chk("reset_crc", {24'h0, crc}, 32'h0);
    drive(0, 1, 1, 8'hA5);
    drive(1, 0, 0, 8'h00);
    chk("load_init", crc_reg, 32'hFFFF_FFFF);

    // Known vector and FCS serialisation
    drive(1, 0, 0, 8'h00);
    for (int i = 0; i < 9; i++) drive(0, 1, 1, s123[i]);
    chk("kv_crc_reg", crc_reg, 32'h9B63_D02C);
    chk("kv_crc", {24'h0, crc}, 32'h26);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("kv_fcs%0d", k), {24'h0, crc}, {24'h0, fcs_k[k]});
      drive(0, 0, 1, 8'h00);
    end
    chk("kv_after_fcs", crc_reg, 32'hFFFF_FFFF);
    chk("kv_after_fcs_crc", {24'h0, crc}, 32'h0);

    // Residue, good and corrupted
    drive(1, 0, 0, 8'h00);
    for (int i = 0; i < 9; i++) drive(0, 1, 1, s123[i]);
    for (int k = 0; k < 4; k++) drive(0, 1, 1, fcs_k[k]);
    chk("residue_good", crc_reg, CRC32_RESIDUE);
    drive(1, 0, 0, 8'h00);
    for (int i = 0; i < 9; i++) drive(0, 1, 1, s123[i]);
    drive(0, 1, 1, 8'h27);
    for (int k = 1; k < 4; k++) drive(0, 1, 1, fcs_k[k]);
    chk("residue_bad", {31'h0, crc_reg != CRC32_RESIDUE}, 32'h1);

    // 100-byte frame, d_valid every other clock, idle cycles carry junk on d
    for (int i = 0; i < 6; i++) frame[i] = 8'hF0 + 8'(i);
    for (int i = 0; i < 6; i++) frame[6+i] = 8'hE0 + 8'(i);
    frame[12] = 8'h08; frame[13] = 8'h00;
    for (int i = 0; i < 86; i++) frame[14+i] = 8'(i);
    drive(1, 0, 0, 8'h00);
    m = CRC32_INIT;
    for (int i = 0; i < 100; i++) begin
      drive(0, 1, 1, frame[i]);
      m = sw_crc(m, frame[i]);
      drive(0, 1, 0, 8'(i * 37));
      chk($sformatf("frm_hold%0d", i), crc_reg, rev32(m));
    end
    fcs = ~m;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("frm_fcs%0d", k), {24'h0, crc}, {24'h0, fcs[8*k +: 8]});
      drive(0, 0, 1, 8'h00);
      drive(0, 0, 0, 8'h00);
    end
    chk("frm_after_fcs", crc_reg, 32'hFFFF_FFFF);
    drive(1, 0, 0, 8'h00);
    for (int i = 0; i < 100; i++) begin
      drive(0, 1, 1, frame[i]);
      drive(0, 0, 0, 8'h00);
    end
    for (int k = 0; k < 4; k++) drive(0, 1, 1, fcs[8*k +: 8]);
    chk("frm_residue", crc_reg, CRC32_RESIDUE);

    // Priority
    drive(1, 0, 0, 8'h00);
    drive(0, 1, 1, 8'h31);
    drive(0, 1, 1, 8'h32);
    drive(1, 1, 1, 8'h55);
    chk("prio_load_over_calc", crc_reg, 32'hFFFF_FFFF);
    drive(0, 1, 1, 8'h31);
    drive(1, 0, 1, 8'h00);
    chk("prio_load_over_shift", crc_reg, 32'hFFFF_FFFF);
    drive(0, 1, 1, 8'h31);
    drive(0, 1, 0, 8'h77);
    chk("calc_no_valid_hold", crc_reg, rev32(sw_crc(CRC32_INIT, 8'h31)));
    drive(0, 1, 1, 8'h32);
    reset = 1'b1;
    drive(0, 1, 1, 8'h33);
    reset = 1'b0;
    chk("reset_mid_frame", crc_reg, 32'hFFFF_FFFF);
    chk("reset_mid_frame_crc", {24'h0, crc}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
